// File: rtl/adc_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and constants for the LTC2308 scan controller.
//               chan_t   - 3-bit ADC channel index
//               sample_t - 12-bit raw / averaged ADC value
//               state_t  - scan sequencer states
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    typedef logic [2:0]  chan_t;
    typedef logic [11:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Clocks between CONVST pulses of the ADC interface
    localparam int ADC_FRAME_CLKS = 16;

endpackage
`default_nettype wire

// File: rtl/adc_scan_controller_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : adc_chan_rr_select
// Description : Combinational masked round-robin channel finder. Returns the
//               lowest enabled channel strictly above i_cur_chan, wrapping to
//               the lowest enabled channel. A single enabled channel repeats.
//               Mask bits at or above NUM_CH are ignored.
// Ports       : i_cur_chan  - channel currently selected
//               i_mask      - channel include mask
//               o_next_chan - next channel (i_cur_chan when nothing enabled)
//               o_any_set   - at least one usable channel enabled
// Revision    : 1.0 - initial release
// ============================================================================
module adc_chan_rr_select
    import adc_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic [2:0] i_cur_chan,
    input  logic [7:0] i_mask,
    output logic [2:0] o_next_chan,
    output logic       o_any_set
);

    localparam logic [7:0] c_CH_MASK = 8'((9'd1 << NUM_CH) - 9'd1);

    logic [7:0] w_eff_mask;
    chan_t      w_idx;
    logic       w_found;

    assign w_eff_mask = i_mask & c_CH_MASK;
    assign o_any_set  = |w_eff_mask;

    // Walk offsets 1..8 from the current channel; the 3-bit add wraps, and
    // offset 8 lands back on the current channel (single-bit mask case).
    always_comb begin
        o_next_chan = i_cur_chan;
        w_found     = 1'b0;
        w_idx       = i_cur_chan;
        for (int i = 1; i <= 8; i++) begin
            w_idx = i_cur_chan + 3'(i);
            if (!w_found && w_eff_mask[w_idx]) begin
                o_next_chan = w_idx;
                w_found     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_controller
// Description : Round-robin channel sequencer for the LTC2308 ADC interface.
//               Detects frames from CONVST, tracks the two-frame
//               config-to-data latency with a tag pipeline, tags each result
//               with its true channel and box-car averages 2^AVG_LOG2 samples
//               per channel into a readable register file.
// Ports       : clk, reset_n (async, active-low)
//               enable, chan_mask          - scan control
//               adc_convst, adc_result     - from ADC interface
//               adc_chan                   - channel select to ADC interface
//               sample_valid/chan/data     - raw tagged sample strobe
//               avg_valid/avg_chan         - averaged value written strobe
//               rd_chan -> rd_data         - combinational register-file read
//               busy                       - high in FILL or RUN
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_controller
    import adc_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    input  logic        adc_convst,
    input  logic [11:0] adc_result,
    output logic [2:0]  adc_chan,
    output logic        sample_valid,
    output logic [2:0]  sample_chan,
    output logic [11:0] sample_data,
    output logic        avg_valid,
    output logic [2:0]  avg_chan,
    input  logic [2:0]  rd_chan,
    output logic [11:0] rd_data,
    output logic        busy
);

    localparam int               ACC_W      = 12 + AVG_LOG2;
    localparam int               CNT_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    // Frame detection
    logic       r_cv_meta;
    logic       r_cv_sync;
    logic       r_cv_prev;
    logic       r_tick;

    // Sequencer
    state_t     r_state;
    logic       r_fill_cnt;
    chan_t      r_adc_chan;
    chan_t      r_tag0;
    chan_t      r_tag1;
    logic       r_tag0_vld;
    logic       r_tag1_vld;
    logic       r_sample_valid;
    chan_t      r_sample_chan;
    sample_t    r_sample_data;
    logic       r_busy;

    chan_t      w_next_chan;
    logic       w_any_set;
    logic       w_accept;

    // Averaging
    logic [ACC_W-1:0] r_acc     [8];
    logic [CNT_W-1:0] r_cnt     [8];
    sample_t          r_regfile [8];
    logic [ACC_W-1:0] w_sum;
    sample_t          w_avg;
    logic             r_avg_valid;
    chan_t            r_avg_chan;

    adc_chan_rr_select #(
        .NUM_CH      (NUM_CH)
    ) u_rr_select (
        .i_cur_chan  (r_adc_chan),
        .i_mask      (chan_mask),
        .o_next_chan (w_next_chan),
        .o_any_set   (w_any_set)
    );

    // CONVST is synchronised, then its rising edge is registered as the
    // frame tick so that everything downstream sees a clean one-clk pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cv_meta <= 1'b0;
            r_cv_sync <= 1'b0;
            r_cv_prev <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cv_meta <= adc_convst;
            r_cv_sync <= r_cv_meta;
            r_cv_prev <= r_cv_sync;
            r_tick    <= r_cv_sync & ~r_cv_prev;
        end
    end

    // A sample is accepted only when still enabled: a disable arriving on
    // the same clock as the tick suppresses the sample.
    assign w_accept = enable && (r_state == RUN) && r_tick && r_tag1_vld;

    // Scan sequencer. tag0 holds the channel that was presented during the
    // frame just started; tag1 is the channel whose result is on adc_result
    // at this tick (two-frame config-to-data latency).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_fill_cnt     <= 1'b0;
            r_adc_chan     <= '0;
            r_tag0         <= '0;
            r_tag1         <= '0;
            r_tag0_vld     <= 1'b0;
            r_tag1_vld     <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_chan  <= '0;
            r_sample_data  <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (!enable) begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_fill_cnt <= 1'b0;
                r_tag0_vld <= 1'b0;
                r_tag1_vld <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= FILL;
                        r_busy     <= 1'b1;
                        r_fill_cnt <= 1'b0;
                    end
                    FILL, RUN: begin
                        if (r_tick) begin
                            if (w_accept) begin
                                r_sample_valid <= 1'b1;
                                r_sample_chan  <= r_tag1;
                                r_sample_data  <= adc_result;
                            end
                            r_tag1     <= r_tag0;
                            r_tag1_vld <= r_tag0_vld;
                            r_tag0     <= r_adc_chan;
                            // Empty mask: hold the select, mark slot empty
                            r_tag0_vld <= w_any_set;
                            if (w_any_set) begin
                                r_adc_chan <= w_next_chan;
                            end
                            if (r_state == FILL) begin
                                r_fill_cnt <= 1'b1;
                                if (r_fill_cnt) begin
                                    r_state <= RUN;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_sum = r_acc[r_tag1] + ACC_W'(adc_result);
    // Dropping the low AVG_LOG2 bits is the truncating divide
    assign w_avg = w_sum[AVG_LOG2 +: 12];

    // Per-channel box-car averaging. The register file survives disable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 8; c++) begin
                r_acc[c]     <= '0;
                r_cnt[c]     <= '0;
                r_regfile[c] <= '0;
            end
            r_avg_valid <= 1'b0;
            r_avg_chan  <= '0;
        end else begin
            r_avg_valid <= 1'b0;
            if (!enable) begin
                for (int c = 0; c < 8; c++) begin
                    r_acc[c] <= '0;
                    r_cnt[c] <= '0;
                end
            end else if (w_accept) begin
                if (r_cnt[r_tag1] == c_CNT_LAST) begin
                    r_regfile[r_tag1] <= w_avg;
                    r_acc[r_tag1]     <= '0;
                    r_cnt[r_tag1]     <= '0;
                    r_avg_valid       <= 1'b1;
                    r_avg_chan        <= r_tag1;
                end else begin
                    r_acc[r_tag1] <= w_sum;
                    r_cnt[r_tag1] <= r_cnt[r_tag1] + CNT_W'(1);
                end
            end
        end
    end

    assign adc_chan     = r_adc_chan;
    assign sample_valid = r_sample_valid;
    assign sample_chan  = r_sample_chan;
    assign sample_data  = r_sample_data;
    assign avg_valid    = r_avg_valid;
    assign avg_chan     = r_avg_chan;
    assign busy         = r_busy;
    assign rd_data      = r_regfile[rd_chan];

endmodule
`default_nettype wire

// File: doc/adc_scan_controller.md
Name: adc_scan_controller

Overview:
Sequences the LTC2308 serial ADC interface across multiple analog channels (joystick X/Y, potentiometers) in round-robin order. It drives the interface's channel select and detects each conversion frame from CONVST. It tracks the two-frame config-to-data pipeline latency, tags every result with its true channel, and box-car averages 2^AVG_LOG2 samples per channel. Averaged values sit in a per-channel register file read by game logic.

Parameters:
NUM_CH, 8, number of channels scanned (1..8); channel index width is fixed at 3.
AVG_LOG2, 2, log2 of samples averaged per channel (0..4); 0 means pass-through.

Ports:
clk  input  1  system clock, same clock that drives the ADC interface
reset_n  input  1  reset, asynchronous, active-low
enable  input  1  scan enable; low forces IDLE
chan_mask  input  8  bit i=1 includes channel i in the scan; bits >= NUM_CH ignored
adc_convst  input  1  CONVST from ADC interface, one clk wide, once per 16 clks
adc_result  input  12  latched ADC result from ADC interface
adc_chan  output  3  channel select to ADC interface
sample_valid  output  1  one-clk strobe: raw tagged sample accepted
sample_chan  output  3  channel tag of the raw sample
sample_data  output  12  raw sample value
avg_valid  output  1  one-clk strobe: averaged value written
avg_chan  output  3  channel of the averaged value
rd_chan  input  3  register-file read address
rd_data  output  12  averaged value of rd_chan, combinational read
busy  output  1  high in FILL or RUN

Behaviour:
- Reset: adc_chan=0; sample_valid, avg_valid and busy=0; sample_chan/data=0; avg_chan=0; all register-file entries, accumulators and sample counters=0; state IDLE.
- Frame detect: adc_convst passes through 2-flop synchronizer plus rising-edge detector, giving frame_tick (3 clk after CONVST rises). All sequencing advances only on frame_tick.
- Pipeline tracking:
  - Channel in effect at CONVST k selects the conversion read out in frame k+1. Its result is latched at the end of frame k+1 and is valid at frame_tick k+2.
  - Two-stage tag shift register (tag0, tag1), each with a valid bit. On frame_tick: capture adc_result with tag1; tag1<=tag0; tag0<=adc_chan (the value presented during the frame just started); then adc_chan<=next channel.
- Next channel: lowest set (masked) bit strictly above current adc_chan, wrapping to lowest set bit. Single set bit means the same channel repeats. Mask all-zero means adc_chan holds and tag0 is written invalid.
- mask changes: take effect at the next selection only; samples already in flight keep their tags and are still delivered.
- States:
  - IDLE: waits for enable=1, then goes to FILL.
  - FILL: the first two frame_ticks load the tags only; no samples are delivered. Then goes to RUN.
  - RUN: on each frame_tick with tag1 valid, pulse sample_valid next clk with sample_chan=tag1 and sample_data=adc_result.
  - enable=0 in any state: next clk goes to IDLE, clears tag valids, accumulators and counters. The register file is retained.
- Averaging per accepted sample on channel c: acc[c]+=sample (width 12+AVG_LOG2, no overflow possible); cnt[c]++.
  - When cnt[c] reaches 2^AVG_LOG2-1 before the add: regfile[c]<=(acc[c]+sample)>>AVG_LOG2 (truncation), acc[c]<=0, cnt[c]<=0, avg_valid/avg_chan pulse same cycle as sample_valid.
- Simultaneous frame_tick and enable falling: disable wins, no sample is emitted.
- Reset mid-scan returns everything to reset values immediately.
- Latency: sample_valid occurs 1 clk after frame_tick, i.e. 4 clk after the CONVST edge.

Decomposition:
- Package adc_pkg: typedef chan_t (logic[2:0]), sample_t (logic[11:0]), state enum {IDLE, FILL, RUN}, constant ADC_FRAME_CLKS=16.
- One natural sub-module: adc_chan_rr_select. Combinational masked round-robin next-channel finder with inputs current channel, mask and NUM_CH, and outputs next channel and any_set.

Test Plan:
- ADC model returns 12'h100+chan for the channel configured two CONVSTs earlier; mask=8'h03, AVG_LOG2=0 -> adc_chan alternates 0,1,0,1; after two discarded frames samples are (0,100h),(1,101h),... and never mis-tagged.
- AVG_LOG2=2, mask=8'h01, samples 10,11,12,14 -> avg_valid once after the 4th sample; regfile[0]=11 (47>>2); counters reset; next 4 samples begin a fresh average.
- mask=8'h85 -> scan order 0,2,7,0,2; switching mask to 8'h02 mid-scan -> in-flight samples still delivered with original tags, then only channel 1.
- mask=0 in RUN -> adc_chan held; in-flight samples drain within 2 frames; then no sample_valid.
- Drop enable on the same clk as frame_tick -> no sample_valid; busy=0 next clk; re-enable -> two frames discarded again; rd_data keeps old averages.
- Assert reset_n=0 mid-RUN for 1 clk -> all outputs and rd_data read 0 immediately; adc_chan=0.
